// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control path: opcodes, immediate formats,
// ALU/result selects and the control FSM state type (TRAP present only with ILLEGAL_TRAP_EN).
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] IMM_I    = 3'b000;
    localparam logic [2:0] IMM_S    = 3'b001;
    localparam logic [2:0] IMM_B    = 3'b010;
    localparam logic [2:0] IMM_J    = 3'b011;
    localparam logic [2:0] IMM_U    = 3'b100;
    localparam logic [2:0] IMM_NONE = 3'b111;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRC_A_PC    = 2'b00;
    localparam logic [1:0] SRC_A_OLDPC = 2'b01;
    localparam logic [1:0] SRC_A_RS1   = 2'b10;

    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_IMM  = 2'b01;
    localparam logic [1:0] SRC_B_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;
    localparam logic [1:0] RES_IMM    = 2'b11;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXEC_R,
        S_EXEC_I,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_JALR,
        S_JALR_PC,
        S_LUI
`ifdef ILLEGAL_TRAP_EN
        , S_TRAP
`endif
    } state_t;

    function automatic logic [2:0] imm_src_of(input logic [6:0] opcode);
        case (opcode)
            OP_LOAD, OP_IMM, OP_JALR: imm_src_of = IMM_I;
            OP_STORE:                 imm_src_of = IMM_S;
            OP_BRANCH:                imm_src_of = IMM_B;
            OP_JAL:                   imm_src_of = IMM_J;
            OP_LUI, OP_AUIPC:         imm_src_of = IMM_U;
            default:                  imm_src_of = IMM_NONE;
        endcase
    endfunction

endpackage

// File: rtl/branch_eval.sv
// Branch condition evaluation from funct3 and ALU compare flags; flags the two reserved
// funct3 codes so the controller can trap on them.
module branch_eval
    import riscv_ctrl_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       lt,
    input  logic       ltu,
    output logic       taken,
    output logic       bad_funct3
);

    always_comb begin
        taken      = 1'b0;
        bad_funct3 = 1'b0;
        case (funct3)
            3'b000:  taken = zero;
            3'b001:  taken = ~zero;
            3'b100:  taken = lt;
            3'b101:  taken = ~lt;
            3'b110:  taken = ltu;
            3'b111:  taken = ~ltu;
            default: bad_funct3 = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle RV32I core. Define ILLEGAL_TRAP_EN to route unknown
// opcodes and reserved branch funct3 codes into a sticky TRAP state.
module multicycle_ctrl
    import riscv_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    input  logic        zero,
    input  logic        lt,
    input  logic        ltu,
    output logic        mem_req,
    output logic        mem_write,
    output logic        adr_src,
    output logic        ir_write,
    output logic        pc_write,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic [1:0]  result_src,
    output logic        reg_write,
    output logic [2:0]  imm_src,
    output logic        illegal
);

    state_t     state_reg, state_next;
    logic [6:0] opcode;
    logic       taken, bad_funct3;
    logic       mem_req_c, mem_write_c, ir_write_c, pc_write_c, reg_write_c;

    assign opcode = instr[6:0];

    branch_eval u_branch_eval (
        .funct3     (instr[14:12]),
        .zero       (zero),
        .lt         (lt),
        .ltu        (ltu),
        .taken      (taken),
        .bad_funct3 (bad_funct3)
    );

    always_comb begin
        state_next  = state_reg;
        mem_req_c   = 1'b0;
        mem_write_c = 1'b0;
        ir_write_c  = 1'b0;
        pc_write_c  = 1'b0;
        reg_write_c = 1'b0;
        adr_src     = 1'b0;
        alu_src_a   = SRC_A_PC;
        alu_src_b   = SRC_B_RS2;
        alu_op      = ALU_ADD;
        result_src  = RES_ALUOUT;
        imm_src     = imm_src_of(opcode);
        case (state_reg)
            S_FETCH: begin
                mem_req_c = 1'b1;
                if (mem_ready) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    alu_src_b  = SRC_B_FOUR;
                    result_src = RES_ALU;
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                // Precompute oldPC+imm into ALUOut: branch/JAL target and AUIPC result.
                alu_src_a = SRC_A_OLDPC;
                alu_src_b = SRC_B_IMM;
                case (opcode)
                    OP_LOAD, OP_STORE: state_next = S_MEMADR;
                    OP_R:              state_next = S_EXEC_R;
                    OP_IMM:            state_next = S_EXEC_I;
                    OP_BRANCH:         state_next = S_BRANCH;
                    OP_JAL:            state_next = S_JAL;
                    OP_JALR:           state_next = S_JALR;
                    OP_LUI:            state_next = S_LUI;
                    OP_AUIPC:          state_next = S_ALUWB;
`ifdef ILLEGAL_TRAP_EN
                    default:           state_next = S_TRAP;
`else
                    default:           state_next = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: begin
                alu_src_a  = SRC_A_RS1;
                alu_src_b  = SRC_B_IMM;
                state_next = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_req_c = 1'b1;
                adr_src   = 1'b1;
                if (mem_ready) state_next = S_MEMWB;
            end
            S_MEMWB: begin
                result_src  = RES_RDATA;
                reg_write_c = 1'b1;
                state_next  = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req_c   = 1'b1;
                mem_write_c = 1'b1;
                adr_src     = 1'b1;
                if (mem_ready) state_next = S_FETCH;
            end
            S_EXEC_R: begin
                alu_src_a  = SRC_A_RS1;
                alu_op     = ALU_FUNCT;
                state_next = S_ALUWB;
            end
            S_EXEC_I: begin
                alu_src_a  = SRC_A_RS1;
                alu_src_b  = SRC_B_IMM;
                alu_op     = ALU_FUNCT;
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_c = 1'b1;
                state_next  = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a  = SRC_A_RS1;
                alu_op     = ALU_SUB;
                pc_write_c = taken;
`ifdef ILLEGAL_TRAP_EN
                state_next = bad_funct3 ? S_TRAP : S_FETCH;
`else
                state_next = S_FETCH;
`endif
            end
            S_JAL: begin
                // PC takes the target held in ALUOut while ALUOut picks up the link address.
                alu_src_a  = SRC_A_OLDPC;
                alu_src_b  = SRC_B_FOUR;
                pc_write_c = 1'b1;
                state_next = S_ALUWB;
            end
            S_JALR: begin
                alu_src_a  = SRC_A_RS1;
                alu_src_b  = SRC_B_IMM;
                state_next = S_JALR_PC;
            end
            S_JALR_PC: begin
                alu_src_a  = SRC_A_OLDPC;
                alu_src_b  = SRC_B_FOUR;
                pc_write_c = 1'b1;
                state_next = S_ALUWB;
            end
            S_LUI: begin
                result_src  = RES_IMM;
                reg_write_c = 1'b1;
                state_next  = S_FETCH;
            end
`ifdef ILLEGAL_TRAP_EN
            S_TRAP: state_next = S_TRAP;
`endif
            default: state_next = S_FETCH;
        endcase
    end

    // Strobes are masked during reset so an abandoned instruction never writes back.
    assign mem_req   = mem_req_c   & ~reset;
    assign mem_write = mem_write_c & ~reset;
    assign ir_write  = ir_write_c  & ~reset;
    assign pc_write  = pc_write_c  & ~reset;
    assign reg_write = reg_write_c & ~reset;

    always_ff @(posedge clk) begin
        if (reset) state_reg <= S_FETCH;
        else       state_reg <= state_next;
    end

`ifdef ILLEGAL_TRAP_EN
    logic illegal_reg;
    logic unused_instr_bits;
    assign unused_instr_bits = ^{instr[31:15], instr[11:7]};

    always_ff @(posedge clk) begin
        if (reset)                    illegal_reg <= 1'b0;
        else if (state_next == S_TRAP) illegal_reg <= 1'b1;
    end
    assign illegal = illegal_reg;
`else
    logic unused_instr_bits;
    assign unused_instr_bits = ^{instr[31:15], instr[11:7], bad_funct3};
    assign illegal = 1'b0;
`endif

endmodule
